// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared CPU definitions: load opcodes, register index width, load decode
package cpu_defs;

  localparam int REG_AW = 5;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;

  typedef enum logic [2:0] {
    LD_NONE,
    LD_W,
    LD_B,
    LD_BU,
    LD_H,
    LD_HU
  } ld_kind_e;

  // Map a primary opcode to the kind of load it performs (LD_NONE for non-loads)
  function automatic ld_kind_e decode_load(input logic [5:0] op);
    case (op)
      OP_LW:   return LD_W;
      OP_LB:   return LD_B;
      OP_LBU:  return LD_BU;
      OP_LH:   return LD_H;
      OP_LHU:  return LD_HU;
      default: return LD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB pipeline bundle delivered to the write-back stage
interface wb_regfile_if;
  import cpu_defs::*;

  logic [31:0]       pc_Wb;
  logic [31:0]       instr_Wb;
  logic [31:0]       dmRd_Wb;
  logic [31:0]       aluAns_Wb;
  logic [31:0]       grfWd_Wb;
  logic [REG_AW-1:0] grfWa_Wb;
  logic              ifWrGrf_Wb;

  modport master (
    output pc_Wb, instr_Wb, dmRd_Wb, aluAns_Wb, grfWd_Wb, grfWa_Wb, ifWrGrf_Wb
  );

  modport slave (
    input pc_Wb, instr_Wb, dmRd_Wb, aluAns_Wb, grfWd_Wb, grfWa_Wb, ifWrGrf_Wb
  );

endinterface

// File: rtl/wb_regfile_load_ext.sv
// rtl/wb_regfile_load_ext.sv - byte/half/word selection and sign/zero extension of load data
module load_ext
  import cpu_defs::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        is_load
);

  ld_kind_e    kind;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign kind    = decode_load(opcode);
  assign is_load = (kind != LD_NONE);

  // Pick the addressed byte/half; offset[0] is irrelevant for halves (alignment trapped upstream)
  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (kind)
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data = {24'h000000, byte_sel};
      LD_H:    data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data = {16'h0000, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage: load extension, 32x32 GRF with write-through bypass, write trace
module wb_regfile
  import cpu_defs::*;
#(
  parameter int NREG     = 32,
  parameter bit TRACE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  wb_regfile_if.slave       wb,
  input  logic [REG_AW-1:0] grfRa1_D,
  input  logic [REG_AW-1:0] grfRa2_D,
  output logic [31:0]       grfRd1_D,
  output logic [31:0]       grfRd2_D,
  output logic [31:0]       wbWd_Wb,
  output logic              traceValid,
  output logic [31:0]       tracePc,
  output logic [REG_AW-1:0] traceWa,
  output logic [31:0]       traceWd,
  output logic [31:0]       wrCount
);

  logic [31:0]       regs [NREG];
  logic [31:0]       load_data;
  logic              is_load;
  logic              we;
  logic              trace_valid;
  logic [31:0]       trace_pc;
  logic [REG_AW-1:0] trace_wa;
  logic [31:0]       trace_wd;
  logic [31:0]       wr_count;
  logic              unused_bits;

  assign unused_bits = ^{wb.instr_Wb[25:0], wb.aluAns_Wb[31:2]};

  load_ext u_load_ext (
    .opcode  (wb.instr_Wb[31:26]),
    .offset  (wb.aluAns_Wb[1:0]),
    .word    (wb.dmRd_Wb),
    .data    (load_data),
    .is_load (is_load)
  );

  assign wbWd_Wb = is_load ? load_data : wb.grfWd_Wb;
  assign we      = wb.ifWrGrf_Wb && (wb.grfWa_Wb != '0) && (int'(wb.grfWa_Wb) < NREG);

  // Register file storage; $0 is never written so it reads as zero from reset onward
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wb.grfWa_Wb] <= wbWd_Wb;
    end
  end

  // Decode read ports: $0 forced to zero, same-cycle write forwarded ahead of the array
  always_comb begin
    grfRd1_D = '0;
    grfRd2_D = '0;
    if (grfRa1_D == '0 || int'(grfRa1_D) >= NREG) grfRd1_D = '0;
    else if (we && grfRa1_D == wb.grfWa_Wb)        grfRd1_D = wbWd_Wb;
    else                                           grfRd1_D = regs[grfRa1_D];
    if (grfRa2_D == '0 || int'(grfRa2_D) >= NREG) grfRd2_D = '0;
    else if (we && grfRa2_D == wb.grfWa_Wb)        grfRd2_D = wbWd_Wb;
    else                                           grfRd2_D = regs[grfRa2_D];
  end

  // Registered trace of the most recent committed write, plus running write count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_wa    <= '0;
      trace_wd    <= '0;
      wr_count    <= '0;
    end else begin
      trace_valid <= we;
      if (we) begin
        trace_pc <= wb.pc_Wb;
        trace_wa <= wb.grfWa_Wb;
        trace_wd <= wbWd_Wb;
        wr_count <= wr_count + 32'd1;
      end
    end
  end

  assign traceValid = TRACE_EN ? trace_valid : 1'b0;
  assign tracePc    = TRACE_EN ? trace_pc    : '0;
  assign traceWa    = TRACE_EN ? trace_wa    : '0;
  assign traceWd    = TRACE_EN ? trace_wd    : '0;
  assign wrCount    = TRACE_EN ? wr_count    : '0;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile against an architectural reference model
module tb_wb_regfile;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  grfRa1_D, grfRa2_D;
  logic [31:0] grfRd1_D, grfRd2_D, wbWd_Wb;
  logic        traceValid;
  logic [31:0] tracePc;
  logic [4:0]  traceWa;
  logic [31:0] traceWd;
  logic [31:0] wrCount;

  int n_tests;
  int n_fail;

  logic [31:0] m_grf [32];
  logic [31:0] m_cnt;
  logic        m_tv;
  logic [31:0] m_pc;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [5:0]  op_tab [8];

  wb_regfile_if bus ();

  wb_regfile #(.NREG(32), .TRACE_EN(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wb         (bus.slave),
    .grfRa1_D   (grfRa1_D),
    .grfRa2_D   (grfRa2_D),
    .grfRd1_D   (grfRd1_D),
    .grfRd2_D   (grfRd2_D),
    .wbWd_Wb    (wbWd_Wb),
    .traceValid (traceValid),
    .tracePc    (tracePc),
    .traceWa    (traceWa),
    .traceWd    (traceWd),
    .wrCount    (wrCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_grf[i] = 32'h0;
    m_cnt = 0; m_tv = 0; m_pc = 0; m_wa = 0; m_wd = 0;
  endtask

  function automatic logic [31:0] ref_wbwd(input logic [31:0] instr, dm, alu, wd);
    int unsigned op, b, h;
    op = instr >> 26;
    b  = (dm >> (8 * alu[1:0])) & 32'hFF;
    h  = (dm >> (16 * alu[1])) & 32'hFFFF;
    case (op)
      35:      return dm;
      32:      return (b >= 128) ? b + 32'hFFFFFF00 : b;
      36:      return b;
      33:      return (h >= 32768) ? h + 32'hFFFF0000 : h;
      37:      return h;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] ra, input logic wr_en,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 0) return 32'h0;
    if (wr_en && ra == wa) return wd;
    return m_grf[ra];
  endfunction

  task automatic set_idle();
    bus.pc_Wb = 0; bus.instr_Wb = 0; bus.dmRd_Wb = 0; bus.aluAns_Wb = 0;
    bus.grfWd_Wb = 0; bus.grfWa_Wb = 0; bus.ifWrGrf_Wb = 0;
    grfRa1_D = 0; grfRa2_D = 0;
  endtask

  task automatic step(input logic [31:0] pc, instr, dm, alu, wd, input logic [4:0] wa,
                      input logic wr, input logic [4:0] ra1, ra2);
    logic [31:0] exp_wd;
    logic        exp_we;
    @(negedge clk);
    bus.pc_Wb = pc; bus.instr_Wb = instr; bus.dmRd_Wb = dm; bus.aluAns_Wb = alu;
    bus.grfWd_Wb = wd; bus.grfWa_Wb = wa; bus.ifWrGrf_Wb = wr;
    grfRa1_D = ra1; grfRa2_D = ra2;
    #1;
    exp_wd = ref_wbwd(instr, dm, alu, wd);
    exp_we = wr && (wa != 0);
    check("wbWd", wbWd_Wb, exp_wd);
    check("rd1", grfRd1_D, ref_read(ra1, exp_we, wa, exp_wd));
    check("rd2", grfRd2_D, ref_read(ra2, exp_we, wa, exp_wd));
    @(posedge clk);
    if (exp_we) begin
      m_grf[wa] = exp_wd;
      m_cnt = m_cnt + 1;
      m_pc = pc; m_wa = wa; m_wd = exp_wd;
    end
    m_tv = exp_we;
    #1;
    check("traceValid", 32'(traceValid), 32'(m_tv));
    check("tracePc", tracePc, m_pc);
    check("traceWa", 32'(traceWa), 32'(m_wa));
    check("traceWd", traceWd, m_wd);
    check("wrCount", wrCount, m_cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cnt_before;
    logic [4:0]  wa, ra1, ra2;
    n_tests = 0;
    n_fail  = 0;
    op_tab[0] = OP_LW;  op_tab[1] = OP_LB; op_tab[2] = OP_LBU; op_tab[3] = OP_LH;
    op_tab[4] = OP_LHU; op_tab[5] = 6'd0;  op_tab[6] = 6'd3;   op_tab[7] = 6'd9;

    reset_n = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_traceValid", 32'(traceValid), 32'h0);
    check("rst_tracePc", tracePc, 32'h0);
    check("rst_traceWa", 32'(traceWa), 32'h0);
    check("rst_traceWd", traceWd, 32'h0);
    check("rst_wrCount", wrCount, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // asynchronous reset after writing $5
    step(32'h100, 32'h00000021, 0, 0, 32'h1234, 5'd5, 1'b1, 5'd5, 5'd0);
    @(negedge clk);
    set_idle();
    grfRa1_D = 5'd5;
    #1 check("pre_rst_rd5", grfRd1_D, 32'h1234);
    #1 reset_n = 1'b0;
    #1;
    check("async_rd5", grfRd1_D, 32'h0);
    check("async_wrCount", wrCount, 32'h0);
    model_reset();
    bus.grfWa_Wb = 5'd7; bus.grfWd_Wb = 32'h55; bus.ifWrGrf_Wb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    set_idle();
    grfRa1_D = 5'd7;
    #1;
    check("drop_in_rst_rd7", grfRd1_D, 32'h0);
    check("drop_in_rst_cnt", wrCount, 32'h0);

    // write to $0 is ignored
    step(32'h200, 32'h24000000, 0, 0, 32'hFFFFFFFF, 5'd0, 1'b1, 5'd0, 5'd0);
    check("w0_rd", grfRd1_D, 32'h0);
    check("w0_tv", 32'(traceValid), 32'h0);
    check("w0_cnt", wrCount, 32'h0);

    // dual bypass
    step(32'h204, 32'h24000000, 0, 0, 32'hDEADBEEF, 5'd8, 1'b1, 5'd8, 5'd8);

    // load extension
    step(32'h300, {OP_LB, 26'h0},  32'h80FF7F01, 32'h3, 0, 5'd10, 1'b1, 5'd0, 5'd0);
    check("lb_off3", wbWd_Wb, 32'hFFFFFF80);
    step(32'h304, {OP_LBU, 26'h0}, 32'h80FF7F01, 32'h1, 0, 5'd11, 1'b1, 5'd0, 5'd0);
    check("lbu_off1", wbWd_Wb, 32'h0000007F);
    step(32'h308, {OP_LH, 26'h0},  32'h80FF7F01, 32'h2, 0, 5'd12, 1'b1, 5'd0, 5'd0);
    check("lh_off2", wbWd_Wb, 32'hFFFF80FF);
    step(32'h30C, {OP_LHU, 26'h0}, 32'h80FF7F01, 32'h0, 0, 5'd13, 1'b1, 5'd0, 5'd0);
    check("lhu_off0", wbWd_Wb, 32'h00007F01);

    // jal trace
    cnt_before = wrCount;
    step(32'h3000, 32'h0C000C02, 0, 0, 32'h00003008, 5'd31, 1'b1, 5'd0, 5'd0);
    check("jal_tv", 32'(traceValid), 32'h1);
    check("jal_pc", tracePc, 32'h3000);
    check("jal_wa", 32'(traceWa), 32'd31);
    check("jal_wd", traceWd, 32'h3008);
    check("jal_cnt", wrCount, cnt_before + 32'd1);

    // back-to-back writes to one register
    step(32'h400, 32'h24000000, 0, 0, 32'hAAAA0001, 5'd9, 1'b1, 5'd9, 5'd0);
    step(32'h404, 32'h24000000, 0, 0, 32'hBBBB0002, 5'd9, 1'b1, 5'd9, 5'd9);
    step(32'h408, 32'h0, 0, 0, 32'h12345678, 5'd9, 1'b0, 5'd9, 5'd8);
    check("b2b_last_wins", grfRd1_D, 32'hBBBB0002);

    // counter wrap
    @(negedge clk);
    force dut.wr_count = 32'hFFFFFFFF;
    #1 release dut.wr_count;
    m_cnt = 32'hFFFFFFFF;
    #1 check("wrap_preload", wrCount, 32'hFFFFFFFF);
    step(32'h500, 32'h24000000, 0, 0, 32'h77, 5'd3, 1'b1, 5'd0, 5'd0);
    check("wrap_zero", wrCount, 32'h0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      wa  = 5'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step($urandom, {op_tab[$urandom_range(0, 7)], 26'($urandom)}, $urandom, $urandom,
           $urandom, wa, 1'($urandom), ra1, ra2);
    end

    // final readback of every register through both ports
    for (int r = 0; r < 32; r++) begin
      step(32'h0, 32'h0, 0, 0, 0, 5'd0, 1'b0, 5'(r), 5'(31 - r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
